// File: rtl/dac_pkg.sv
// dac_pkg: shared constants and state encoding for the serial DAC transmitter.
package dac_pkg;
  localparam int FRAME_W = 16;
  localparam int DAC_W = 12;
  localparam logic [3:0] CTRL_BITS = 4'b0000;
  localparam logic [DAC_W-1:0] CODE_MID = 12'h800;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GUARD} state_t;
endpackage

// File: rtl/dac_code_conv.sv
// dac_code_conv: signed sample -> offset-binary DAC code (arithmetic shift, saturate, offset).
module dac_code_conv #(
  parameter int DATA_W = 18,
  parameter int SHIFT = 6,
  parameter int DAC_W = dac_pkg::DAC_W
) (
  input  logic signed [DATA_W-1:0] sample,
  output logic        [DAC_W-1:0]  code
);
  localparam logic signed [DATA_W-1:0] HI = DATA_W'((1 << (DAC_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] LO = ~HI;
  localparam logic signed [DATA_W-1:0] MID = HI + DATA_W'(1);
  logic signed [DATA_W-1:0] v, sat;
  always_comb begin
    v = sample >>> SHIFT;
    sat = v > HI ? HI : v < LO ? LO : v;
    code = DAC_W'(sat + MID);
  end
endmodule

// File: rtl/dac_serial_tx.sv
// dac_serial_tx: converts a filter sample to a 16-bit DAC frame and shifts it out MSB first
// on sync_n/sclk/din, followed by a guard interval with sync_n high.
module dac_serial_tx #(
  parameter int CLK_DIV = 2,
  parameter int SHIFT = 6,
  parameter int DATA_W = 18,
  parameter int DAC_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     busy,
  output logic                     done,
  output logic                     sync_n,
  output logic                     sclk,
  output logic                     din
);
  import dac_pkg::*;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] bitc, bitc_nx;
  logic [FRAME_W-1:0] sreg, sreg_nx;
  logic sclk_nx, sync_nx, din_nx, tick;
  logic [DAC_W-1:0] code;
  dac_code_conv #(.DATA_W(DATA_W), .SHIFT(SHIFT), .DAC_W(DAC_W)) u_conv (
    .sample(sample),
    .code(code)
  );
  assign tick = cnt == CMAX;
  assign busy = state != ST_IDLE;
  assign done = state == ST_GUARD && tick;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    bitc_nx = bitc;
    sreg_nx = sreg;
    sclk_nx = sclk;
    sync_nx = sync_n;
    din_nx = din;
    case (state)
      ST_IDLE: if (start) begin
        state_nx = ST_SHIFT;
        cnt_nx = '0;
        bitc_nx = '0;
        sreg_nx = {CTRL_BITS, code};
        sync_nx = 1'b0;
        sclk_nx = 1'b1;
        din_nx = sreg_nx[FRAME_W-1];
      end
      ST_SHIFT: begin
        cnt_nx = tick ? '0 : cnt + 1'b1;
        if (tick) begin
          sclk_nx = ~sclk;
          // rising edges advance the data; the one after bit 0 closes the frame
          if (!sclk && bitc == 4'd15) begin
            state_nx = ST_GUARD;
            sync_nx = 1'b1;
            din_nx = 1'b0;
          end else if (!sclk) begin
            bitc_nx = bitc + 1'b1;
            sreg_nx = sreg << 1;
            din_nx = sreg[FRAME_W-2];
          end
        end
      end
      ST_GUARD: begin
        cnt_nx = tick ? '0 : cnt + 1'b1;
        if (tick) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      bitc <= '0;
      sreg <= '0;
      sclk <= 1'b1;
      sync_n <= 1'b1;
      din <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bitc <= bitc_nx;
      sreg <= sreg_nx;
      sclk <= sclk_nx;
      sync_n <= sync_nx;
      din <= din_nx;
    end
  end
endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: random and directed frames checked against an arithmetic reference model.
module tb_dac_serial_tx;
  localparam int CLK_DIV = 2;
  localparam int SHIFT = 6;
  localparam int PER = 33 * CLK_DIV + 1;
  logic clk = 0, rst = 1, start = 0;
  logic [17:0] sample = '0;
  logic busy, done, sync_n, sclk, din;
  logic [17:0] cs = '0;
  logic [11:0] cc;

  dac_serial_tx #(.CLK_DIV(CLK_DIV), .SHIFT(SHIFT), .DATA_W(18), .DAC_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .sample(sample),
    .busy(busy), .done(done), .sync_n(sync_n), .sclk(sclk), .din(din)
  );
  dac_code_conv #(.DATA_W(18), .SHIFT(4), .DAC_W(12)) u_c4 (.sample(cs), .code(cc));

  always #5 clk = ~clk;

  int nchk = 0, npass = 0;
  task automatic check(string tag, int got, int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // floor division by 2**sh, clamp to the 12-bit signed range, then offset to unsigned
  function automatic int ref_code(logic [17:0] s, int sh);
    int x, d, v;
    x = int'($signed(s));
    d = 1 << sh;
    v = x >= 0 ? x / d : -((-x + d - 1) / d);
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v + 2048;
  endfunction

  logic psclk = 1, psync = 1;
  int cap = 0, nb = 0, low = 0, blen = 0, gap = 0, dcnt = 0;
  int fq[$], fnb[$], flow[$], bq[$], gq[$];

  always @(negedge clk) begin
    if (rst) begin
      cap = 0; nb = 0; low = 0; blen = 0; gap = 0; psclk = 1; psync = 1;
    end else begin
      if (!sync_n) low++; else gap++;
      if (!sync_n && psclk && !sclk) begin cap = (cap << 1) | int'(din); nb++; end
      if (sync_n && !psync) begin
        fq.push_back(cap); fnb.push_back(nb); flow.push_back(low);
        cap = 0; nb = 0; low = 0; gap = 1;
      end
      if (!sync_n && psync) gq.push_back(gap);
      if (busy) blen++;
      else if (blen > 0) begin bq.push_back(blen); blen = 0; end
      if (done) dcnt++;
      psclk = sclk; psync = sync_n;
    end
  end

  task automatic clr();
    fq.delete(); fnb.delete(); flow.delete(); bq.delete(); gq.delete(); dcnt = 0;
  endtask

  task automatic wait_idle(string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == 400) check({tag, "_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic send(logic [17:0] s);
    @(negedge clk); start = 1; sample = s;
    @(negedge clk); start = 0; sample = 18'($urandom);
    wait_idle("send");
  endtask

  task automatic check_frame(string tag, logic [17:0] s);
    check({tag, "_count"}, fq.size(), 1);
    if (fq.size() > 0) begin
      check({tag, "_word"}, fq.pop_front(), ref_code(s, SHIFT));
      check({tag, "_bits"}, fnb.pop_front(), 16);
      check({tag, "_synclow"}, flow.pop_front(), 32 * CLK_DIV);
    end
    check({tag, "_busycnt"}, bq.size(), 1);
    if (bq.size() > 0) check({tag, "_busylen"}, bq.pop_front(), 33 * CLK_DIV);
    check({tag, "_done"}, dcnt, 1);
    clr();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [17:0] dir[4];
    logic [17:0] c4[5];
    logic [17:0] sv[200];
    logic [17:0] a, b, ig;
    int i;
    dir = '{18'h00000, 18'h1FFFF, 18'h20000, 18'h00040};
    c4 = '{18'h1FFFF, 18'h20000, 18'h00000, 18'h00010, 18'h3FFEF};
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_sync_n", int'(sync_n), 1);
    check("rst_sclk", int'(sclk), 1);
    check("rst_din", int'(din), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 0;
    @(negedge clk);
    clr();

    for (int k = 0; k < 4; k++) begin send(dir[k]); check_frame("dir", dir[k]); end
    for (int k = 0; k < 6; k++) begin
      a = 18'($urandom);
      send(a); check_frame("rnd", a);
    end

    for (int k = 0; k < 9; k++) begin
      cs = k < 5 ? c4[k] : 18'($urandom);
      #1 check("conv_sh4", int'(cc), ref_code(cs, 4));
    end

    // starts during a frame and on the edge busy falls are dropped
    clr();
    a = 18'h00C40; b = 18'h1F000; ig = 18'h3F000;
    @(negedge clk); start = 1; sample = a;
    @(negedge clk); start = 0; sample = ig;
    repeat (4) @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (14) @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (19) @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (i = 0; i < 200; i++) begin @(negedge clk); if (done) break; end
    if (i == 200) check("ign_done_timeout", 0, 1);
    start = 1; sample = ig;
    @(negedge clk); sample = b;
    @(negedge clk); start = 0;
    wait_idle("ign");
    check("ign_frames", fq.size(), 2);
    if (fq.size() == 2) begin
      check("ign_word0", fq[0], ref_code(a, SHIFT));
      check("ign_word1", fq[1], ref_code(b, SHIFT));
    end
    check("ign_done", dcnt, 2);
    for (int k = 0; k < bq.size(); k++) check("ign_busylen", bq[k], 33 * CLK_DIV);

    // reset in the middle of a frame
    clr();
    a = 18'($urandom);
    @(negedge clk); start = 1; sample = a;
    @(negedge clk); start = 0;
    for (i = 0; i < 200; i++) begin @(negedge clk); if (nb >= 7) break; end
    if (i == 200) check("mid_fall_timeout", 0, 1);
    #2 rst = 1;
    #1;
    check("mid_sync_n", int'(sync_n), 1);
    check("mid_sclk", int'(sclk), 1);
    check("mid_din", int'(din), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("mid_partial", fq.size(), 0);
    clr();
    b = 18'($urandom);
    send(b); check_frame("mid_after", b);

    // start held high: accepts every PER cycles, each with its own sample
    clr();
    for (int k = 0; k < 200; k++) sv[k] = 18'($urandom);
    for (int k = 0; k < 200; k++) begin @(negedge clk); start = 1; sample = sv[k]; end
    @(negedge clk); start = 0;
    wait_idle("b2b");
    check("b2b_frames", fq.size(), 3);
    for (int k = 0; k < fq.size() && k < 3; k++) check("b2b_word", fq[k], ref_code(sv[k * PER], SHIFT));
    for (int k = 0; k < gq.size(); k++) check("b2b_gap", int'(gq[k] >= CLK_DIV), 1);
    check("b2b_done", dcnt, 3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
